mux64_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one 64:1 select datapath (mux64x1) among 64 requesters.
- Picks one pending requester and drives the 6-bit `sel` of the downstream 64x1 mux.
- Holds the grant until the consumer signals completion, a timeout expires, or the requester withdraws.
- Sits directly in front of the mux: `sel` output connects to the mux `sel`; `grant_valid` qualifies the mux `out`.

---
 rtl/mux64_rr_scheduler_pkg.sv | 21 ++
 rtl/mux64_rr_scheduler_rr_pick.sv | 33 +++
 rtl/mux64_rr_scheduler.sv | 109 ++++++++++
 tb/tb_mux64_rr_scheduler.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux64_rr_scheduler_pkg.sv
// Shared types and constants for the 64-way round-robin mux scheduler.
package mux64_rr_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam int N_REQ            = 64;
    localparam int SEL_W            = 6;
    localparam int DEFAULT_MAX_HOLD = 255;

    // Hold counter width: enough bits to count up to MAX_HOLD, never zero.
    function automatic int hold_cnt_w(input int max_hold);
        int w;
        w = $clog2(max_hold + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux64_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N     = mux64_rr_scheduler_pkg::N_REQ,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [SEL_W-1:0] w_off;

    // Rotating right by ptr puts the requester at ptr into bit 0.
    assign w_dbl = {req, req} >> ptr;
    assign w_rot = w_dbl[N-1:0];

    // Priority encode the lowest set bit of the rotated vector.
    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = SEL_W'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = w_off + ptr;

endmodule

// File: rtl/mux64_rr_scheduler.sv
// Round-robin scheduler driving the select of a shared 64:1 mux.
module mux64_rr_scheduler #(
    parameter int N        = mux64_rr_scheduler_pkg::N_REQ,
    parameter int SEL_W    = mux64_rr_scheduler_pkg::SEL_W,
    parameter int MAX_HOLD = mux64_rr_scheduler_pkg::DEFAULT_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic             grant_valid,
    output logic [N-1:0]     grant_onehot,
    output logic             timeout,
    output logic             busy
);

    import mux64_rr_scheduler_pkg::*;

    localparam int               CNT_W    = hold_cnt_w(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [N-1:0]     ONE_HOT0 = N'(1);

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_sel, w_sel_nxt;
    logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_timeout, w_timeout_nxt;

    logic             w_found;
    logic [SEL_W-1:0] w_win;
    logic             w_hold_expired;

    rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_win)
    );

    // The timeout only exists when MAX_HOLD is non-zero.
    assign w_hold_expired = (MAX_HOLD != 0) && (r_cnt == CNT_LAST);

    // State, select, pointer, hold counter and timeout pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_sel     <= '0;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sel     <= w_sel_nxt;
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state logic: grant in IDLE, hold until done/withdraw/timeout, one gap cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_sel_nxt     = r_sel;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en && w_found) begin
                    w_sel_nxt   = w_win;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // done and withdrawal take priority, so a coincident timeout is silent.
                if (done || !req[r_sel]) begin
                    w_ptr_nxt   = r_sel + SEL_W'(1);
                    w_state_nxt = ST_RELEASE;
                end else if (w_hold_expired) begin
                    w_ptr_nxt     = r_sel + SEL_W'(1);
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = ST_RELEASE;
                end else if (r_cnt != CNT_MAX) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign sel          = r_sel;
    assign grant_valid  = (r_state == ST_GRANT);
    assign grant_onehot = grant_valid ? (ONE_HOT0 << r_sel) : '0;
    assign timeout      = r_timeout;
    assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mux64_rr_scheduler.sv
// Self-checking bench for mux64_rr_scheduler with a short hold limit.
module tb_mux64_rr_scheduler;

    localparam int N        = 64;
    localparam int SEL_W    = 6;
    localparam int MAX_HOLD = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             done = 1'b0;
    logic [N-1:0]     req = '0;
    logic [SEL_W-1:0] sel;
    logic             grant_valid;
    logic [N-1:0]     grant_onehot;
    logic             timeout;
    logic             busy;

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    mux64_rr_scheduler #(
        .N        (N),
        .SEL_W    (SEL_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .req          (req),
        .done         (done),
        .sel          (sel),
        .grant_valid  (grant_valid),
        .grant_onehot (grant_onehot),
        .timeout      (timeout),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who holds the grant, for how many cycles, and the gap after it.
    bit m_active = 1'b0;
    int m_sel    = 0;
    int m_ptr    = 0;
    int m_held   = 0;
    int m_gap    = 0;
    bit m_to     = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0; m_sel = 0; m_ptr = 0; m_held = 0; m_gap = 0; m_to = 1'b0;
        end else begin
            m_to = 1'b0;
            if (m_active) begin
                if (done || !req[m_sel]) begin
                    m_active = 1'b0; m_gap = 1; m_ptr = (m_sel + 1) % N;
                end else if (MAX_HOLD != 0 && m_held == MAX_HOLD) begin
                    m_active = 1'b0; m_gap = 1; m_ptr = (m_sel + 1) % N; m_to = 1'b1;
                end else begin
                    m_held++;
                end
            end else if (m_gap > 0) begin
                m_gap--;
            end else if (en && req != '0) begin
                for (int k = 0; k < N; k++) begin
                    if (req[(m_ptr + k) % N]) begin
                        m_sel = (m_ptr + k) % N;
                        break;
                    end
                end
                m_active = 1'b1;
                m_held   = 1;
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of granted indices.
    logic [SEL_W-1:0] log_q[$];
    logic             prev_gv  = 1'b0;
    int               to_count = 0;
    logic [N-1:0]     exp_oh;

    always @(negedge clk) begin
        exp_oh = m_active ? (N'(1) << m_sel) : '0;
        chk("grant_valid", 64'(grant_valid), 64'(m_active));
        chk("sel", 64'(sel), 64'(m_sel));
        chk("grant_onehot", 64'(grant_onehot), 64'(exp_oh));
        chk("timeout", 64'(timeout), 64'(m_to));
        chk("busy", 64'(busy), 64'(m_active || (m_gap > 0)));
        if (grant_valid && !prev_gv) log_q.push_back(sel);
        prev_gv = grant_valid;
        if (timeout) to_count++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input int budget);
        int i;
        i = 0;
        while (!grant_valid && i < budget) begin
            tick();
            i++;
        end
        asserts++;
        if (!grant_valid) begin
            fails++;
            $display("FAIL wait_grant: grant_valid=0 after %0d cycles, required 1", budget);
        end
    endtask

    task automatic serve();
        wait_grant(20);
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int start;
        int n_log;

        // All requesters pending from reset: sequential service and 63 -> 0 wrap.
        en  = 1'b1;
        req = '1;
        tick();
        tick();
        rst_n = 1'b1;
        log_q.delete();
        tick();
        chk("first_grant_valid", 64'(grant_valid), 64'd1);
        chk("first_grant_sel", 64'(sel), 64'd0);
        for (int g = 0; g < 65; g++) serve();
        req = '0;
        tick();
        chk("seq_count", 64'(log_q.size()), 64'd65);
        if (log_q.size() >= 65) begin
            chk("seq0", 64'(log_q[0]), 64'd0);
            chk("seq1", 64'(log_q[1]), 64'd1);
            chk("seq2", 64'(log_q[2]), 64'd2);
            chk("seq63", 64'(log_q[63]), 64'd63);
            chk("seq64_wrap", 64'(log_q[64]), 64'd0);
        end

        // Sparse requesters 5, 40, 63 served in round-robin order.
        do_reset();
        log_q.delete();
        req = (N'(1) << 5) | (N'(1) << 40) | (N'(1) << 63);
        wait_grant(20);
        chk("sparse_onehot", 64'(grant_onehot), 64'h0000_0000_0000_0020);
        for (int g = 0; g < 4; g++) serve();
        req = '0;
        tick();
        chk("sparse_count", 64'(log_q.size()), 64'd4);
        if (log_q.size() >= 4) begin
            chk("sparse0", 64'(log_q[0]), 64'd5);
            chk("sparse1", 64'(log_q[1]), 64'd40);
            chk("sparse2", 64'(log_q[2]), 64'd63);
            chk("sparse3", 64'(log_q[3]), 64'd5);
        end

        // Timeout: requester 7 never completes, next grant goes to 20.
        do_reset();
        req = (N'(1) << 7) | (N'(1) << 20);
        start = to_count;
        wait_grant(20);
        chk("to_sel", 64'(sel), 64'd7);
        cnt = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (grant_valid) cnt++;
            else break;
        end
        chk("to_hold_cycles", 64'(cnt), 64'd4);
        chk("to_pulse_level", 64'(timeout), 64'd1);
        wait_grant(20);
        chk("to_pulses", 64'(to_count - start), 64'd1);
        chk("to_next_sel", 64'(sel), 64'd20);
        req  = '0;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();

        // done on the very cycle the hold limit would fire: done wins.
        do_reset();
        req = N'(1) << 9;
        wait_grant(20);
        tick();
        tick();
        tick();
        start = to_count;
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = '0;
        chk("coinc_gv", 64'(grant_valid), 64'd0);
        chk("coinc_timeout", 64'(timeout), 64'd0);
        tick();
        chk("coinc_pulses", 64'(to_count - start), 64'd0);

        // Withdrawal of 12 mid-grant, then en=0 during the following grant.
        do_reset();
        req = (N'(1) << 12) | (N'(1) << 13);
        wait_grant(20);
        chk("wd_sel", 64'(sel), 64'd12);
        req = (N'(1) << 13) | (N'(1) << 5);
        tick();
        chk("wd_release", 64'(grant_valid), 64'd0);
        chk("wd_timeout", 64'(timeout), 64'd0);
        wait_grant(20);
        chk("wd_next_sel", 64'(sel), 64'd13);
        en = 1'b0;
        tick();
        chk("en_hold_gv", 64'(grant_valid), 64'd1);
        done = 1'b1;
        tick();
        done = 1'b0;
        n_log = log_q.size();
        for (int i = 0; i < 8; i++) tick();
        chk("en_blocked_gv", 64'(grant_valid), 64'd0);
        chk("en_blocked_log", 64'(log_q.size()), 64'(n_log));
        en = 1'b1;
        wait_grant(20);
        chk("en_resume_sel", 64'(sel), 64'd5);
        req  = '0;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();

        // Asynchronous reset in the middle of a grant at 33.
        do_reset();
        req = N'(1) << 40;
        serve();
        req = N'(1) << 33;
        wait_grant(20);
        chk("ar_sel_before", 64'(sel), 64'd33);
        tick();
        rst_n = 1'b0;
        #1;
        chk("ar_gv", 64'(grant_valid), 64'd0);
        chk("ar_sel", 64'(sel), 64'd0);
        chk("ar_onehot", 64'(grant_onehot), 64'd0);
        chk("ar_busy", 64'(busy), 64'd0);
        chk("ar_timeout", 64'(timeout), 64'd0);
        req = (N'(1) << 2) | (N'(1) << 50);
        tick();
        tick();
        rst_n = 1'b1;
        wait_grant(20);
        chk("ar_first_after", 64'(sel), 64'd2);
        req  = '0;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
